// File: rtl/popcount_pkg.sv
`default_nettype none
// ============================================================================
// Module   : popcount_pkg
// Purpose  : Shared definitions for the popcount AXI4-Lite register block:
//            register offsets, AXI response codes, FSM state types and the
//            write-strobe masking helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package popcount_pkg;

  // Byte offsets of the four 32-bit registers
  localparam logic [3:0] ADDR_DATA  = 4'h0;
  localparam logic [3:0] ADDR_COUNT = 4'h4;
  localparam logic [3:0] ADDR_CTRL  = 4'h8;
  localparam logic [3:0] ADDR_WCNT  = 4'hC;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_EXEC = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Bytes whose strobe bit is low are forced to zero rather than left stale.
  function automatic logic [31:0] strb_mask(input logic [31:0] data,
                                            input logic [3:0]  strb);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[i*8 +: 8] = strb[i] ? data[i*8 +: 8] : 8'h00;
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/popcount_axil_regs.sv
`default_nettype none
// ============================================================================
// Module   : popcount_axil_regs
// Purpose  : AXI4-Lite slave register file for the popcount engine. Turns
//            DATA/CTRL writes into single-cycle WRITE_VALID / COUNT_RST
//            pulses, exposes COUNT, COUNT_BUSY and a delivered-write tally.
//            DATA writes wait for COUNT_BUSY low, up to STALL_LIMIT cycles,
//            after which they are dropped with SLVERR.
// Ports    : S_AXI_ACLK, S_AXI_ARESETN       - clock, async active-low reset
//            S_AXI_AW*/W*/B*                 - AXI-Lite write channels
//            S_AXI_AR*/R*                    - AXI-Lite read channels
//            COUNT, COUNT_BUSY               - status from the popcount core
//            WRITE_DATA, WRITE_VALID         - MMIO word + strobe to the core
//            COUNT_RST                       - one-cycle count clear request
// Revision : 1.0 - initial release
// ============================================================================
module popcount_axil_regs
  import popcount_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int STALL_LIMIT        = 1024
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [31:0]                     COUNT,
  input  logic                            COUNT_BUSY,
  output logic [31:0]                     WRITE_DATA,
  output logic                            WRITE_VALID,
  output logic                            COUNT_RST
);

  localparam int c_stall_w = $clog2(STALL_LIMIT + 1);

  // ---------------- write path state ----------------
  wr_state_t              r_wr_state, w_wr_state_nxt;
  logic                   r_aw_held, r_w_held;
  logic                   r_awready, r_wready;
  logic [3:0]             r_awaddr;
  logic [31:0]            r_wdata;
  logic [c_stall_w-1:0]   r_stall;
  logic [1:0]             r_bresp;
  logic [31:0]            r_wcnt;

  logic w_aw_fire, w_w_fire, w_aw_have, w_w_have;
  logic w_aw_held_nxt, w_w_held_nxt;
  logic w_is_data, w_is_ctrl, w_stall_expire;
  logic w_write_valid, w_count_rst;

  // ---------------- read path state ----------------
  rd_state_t   r_rd_state, w_rd_state_nxt;
  logic        r_arready;
  logic [31:0] r_rdata;
  logic [31:0] w_rd_mux;
  logic        w_ar_fire;

  // Byte-lane address bits carry no meaning for 32-bit registers.
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign w_aw_fire = S_AXI_AWVALID & r_awready;
  assign w_w_fire  = S_AXI_WVALID  & r_wready;
  assign w_aw_have = r_aw_held | w_aw_fire;
  assign w_w_have  = r_w_held  | w_w_fire;

  assign w_is_data      = (r_awaddr == ADDR_DATA);
  assign w_is_ctrl      = (r_awaddr == ADDR_CTRL);
  assign w_stall_expire = COUNT_BUSY && (r_stall == c_stall_w'(STALL_LIMIT - 1));

  // A channel stays "held" only while the other one has not arrived yet;
  // once both are in, the FSM leaves W_IDLE and the flags are cleared.
  assign w_aw_held_nxt = (r_wr_state == W_IDLE) && w_aw_have && !w_w_have;
  assign w_w_held_nxt  = (r_wr_state == W_IDLE) && w_w_have  && !w_aw_have;

  // ---------------- write FSM: state register ----------------
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_wr_state <= W_IDLE;
    else                r_wr_state <= w_wr_state_nxt;
  end

  // ---------------- write FSM: next state ----------------
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    case (r_wr_state)
      W_IDLE: if (w_aw_have && w_w_have) w_wr_state_nxt = W_EXEC;
      W_EXEC: begin
        if (!w_is_data || !COUNT_BUSY || w_stall_expire) w_wr_state_nxt = W_RESP;
      end
      W_RESP: if (S_AXI_BREADY) w_wr_state_nxt = W_IDLE;
      default: w_wr_state_nxt = W_IDLE;
    endcase
  end

  // ---------------- write FSM: outputs ----------------
  // The strobe tracks COUNT_BUSY in the same cycle so the word is delivered
  // the first cycle the core can accept it.
  always_comb begin
    w_write_valid = 1'b0;
    w_count_rst   = 1'b0;
    if (r_wr_state == W_EXEC) begin
      w_write_valid = w_is_data && !COUNT_BUSY;
      // r_wdata is already strobe-masked, so bit0 set implies WSTRB[0] was set
      w_count_rst   = w_is_ctrl && r_wdata[0];
    end
  end

  assign WRITE_VALID   = w_write_valid;
  assign COUNT_RST     = w_count_rst;
  assign WRITE_DATA    = r_wdata;
  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = (r_wr_state == W_RESP);
  assign S_AXI_BRESP   = r_bresp;

  // ---------------- write datapath ----------------
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_stall   <= '0;
      r_bresp   <= RESP_OKAY;
      r_wcnt    <= '0;
    end else begin
      r_aw_held <= w_aw_held_nxt;
      r_w_held  <= w_w_held_nxt;
      r_awready <= (w_wr_state_nxt == W_IDLE) && !w_aw_held_nxt;
      r_wready  <= (w_wr_state_nxt == W_IDLE) && !w_w_held_nxt;

      if (w_aw_fire) r_awaddr <= {S_AXI_AWADDR[3:2], 2'b00};
      if (w_w_fire)  r_wdata  <= strb_mask(S_AXI_WDATA, S_AXI_WSTRB);

      if ((r_wr_state == W_EXEC) && w_is_data && COUNT_BUSY)
        r_stall <= r_stall + c_stall_w'(1);
      else if ((r_wr_state == W_RESP) && S_AXI_BREADY)
        r_stall <= '0;

      // Leaving W_EXEC on a busy DATA write can only mean the stall expired.
      if ((r_wr_state == W_EXEC) && (w_wr_state_nxt == W_RESP))
        r_bresp <= (w_is_data && COUNT_BUSY) ? RESP_SLVERR : RESP_OKAY;

      if (w_count_rst)        r_wcnt <= '0;
      else if (w_write_valid) r_wcnt <= r_wcnt + 32'd1;
    end
  end

  // ---------------- read FSM: state register ----------------
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_rd_state <= R_IDLE;
    else                r_rd_state <= w_rd_state_nxt;
  end

  assign w_ar_fire = S_AXI_ARVALID & r_arready;

  // ---------------- read FSM: next state ----------------
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    case (r_rd_state)
      R_IDLE:  if (w_ar_fire)    w_rd_state_nxt = R_DATA;
      R_DATA:  if (S_AXI_RREADY) w_rd_state_nxt = R_IDLE;
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  // ---------------- read FSM: outputs ----------------
  always_comb begin
    w_rd_mux = '0;
    case ({S_AXI_ARADDR[3:2], 2'b00})
      ADDR_COUNT: w_rd_mux = COUNT;
      ADDR_CTRL:  w_rd_mux = {31'b0, COUNT_BUSY};
      ADDR_WCNT:  w_rd_mux = r_wcnt;
      default:    w_rd_mux = '0;
    endcase
  end

  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = (r_rd_state == R_DATA);
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = RESP_OKAY;

  // Sources are captured in the handshake cycle, so a same-cycle update of
  // COUNT or WCNT is not visible to that read.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_arready <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_arready <= (w_rd_state_nxt == R_IDLE);
      if (w_ar_fire) r_rdata <= w_rd_mux;
    end
  end

endmodule
`default_nettype wire

// File: doc/popcount_axil_regs.md
Name: popcount_axil_regs

Overview:
- AXI4-Lite slave register file for the popcount engine's control/MMIO side; sits between the processor's AXI-Lite interconnect and the popcount core.
- Turns register writes into single-cycle WRITE_DATA/WRITE_VALID and COUNT_RST pulses, and exposes COUNT, COUNT_BUSY and a DATA-write tally for readback.
- The popcount core drops MMIO data while its stream input is active, so this block stalls DATA writes until COUNT_BUSY is low.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI-Lite data width; only 32 supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; 4 registers decoded on addr[3:2].
- STALL_LIMIT, 1024, maximum cycles a DATA write waits on COUNT_BUSY before it is dropped with SLVERR.

Ports:
- S_AXI_ACLK in 1: clock.
- S_AXI_ARESETN in 1: reset, asynchronous assert, active-low.
- S_AXI_AWADDR in 4, S_AXI_AWVALID in 1, S_AXI_AWREADY out 1: write address channel.
- S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1: write data channel.
- S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1: write response channel.
- S_AXI_ARADDR in 4, S_AXI_ARVALID in 1, S_AXI_ARREADY out 1: read address channel.
- S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1: read data channel.
- COUNT in 32: running popcount from the core.
- COUNT_BUSY in 1: core is consuming stream data.
- WRITE_DATA out 32: MMIO word to the core.
- WRITE_VALID out 1: one-cycle strobe qualifying WRITE_DATA.
- COUNT_RST out 1: one-cycle synchronous clear request to the core.

Behaviour:
- Register map:
  - 0x0 DATA: write-only; reads return 0.
  - 0x4 COUNT: read-only; returns COUNT.
  - 0x8 CTRL: write bit0=1 clears the count; read bit0 = COUNT_BUSY, other bits 0.
  - 0xC WCNT: read-only; 32-bit count of DATA writes delivered to the core.
- Writes to read-only registers: no effect, BRESP=OKAY.
- Reset (async, ARESETN low):
  - All READY/VALID outputs 0; BRESP/RRESP 0; RDATA 0.
  - WRITE_DATA 0, WRITE_VALID 0, COUNT_RST 0; WCNT 0; stall counter 0; both FSMs return to IDLE.
  - Reset mid-transaction abandons the transaction; no pulse is emitted afterwards.
- Write FSM, states W_IDLE, W_EXEC, W_RESP:
  - W_IDLE: AWREADY and WREADY are high independently until their own channel handshakes. AW and W may arrive in either order or in the same cycle; each is latched. When both are held, go to W_EXEC. The *READY of a latched channel drops.
  - W_EXEC, DATA address:
    - If COUNT_BUSY=0: drive WRITE_VALID=1 for exactly one cycle, WRITE_DATA = WDATA with un-strobed bytes forced to 0, WCNT+1 (wraps 0xFFFFFFFF->0). Then W_RESP, BRESP=OKAY.
    - If COUNT_BUSY=1: wait and increment the stall counter. When it reaches STALL_LIMIT: no pulse, WCNT unchanged, W_RESP with BRESP=SLVERR.
  - W_EXEC, CTRL address:
    - If WSTRB[0]=1 and WDATA[0]=1: COUNT_RST=1 for one cycle and WCNT cleared to 0.
    - Go to W_RESP with OKAY; COUNT_RST does not wait on COUNT_BUSY.
  - W_EXEC, other addresses: go straight to W_RESP, OKAY.
  - W_RESP: BVALID held until BREADY; then W_IDLE and the stall counter clears.
  - Latency, not busy: AW+W handshake at edge N; WRITE_VALID high in cycle N+1; BVALID from N+2.
- Read FSM, states R_IDLE, R_DATA (independent of the write FSM):
  - R_IDLE: ARREADY=1. On handshake, load RDATA from the selected source as sampled in the handshake cycle; RRESP=OKAY; go to R_DATA.
  - R_DATA: RVALID held with RDATA stable until RREADY; then R_IDLE.
  - One read outstanding; ARREADY=0 while in R_DATA.
- Simultaneous events:
  - A COUNT read in the same cycle as a WRITE_VALID pulse returns the pre-update COUNT.
  - A WCNT read in the cycle WCNT changes returns the old value.
- WRITE_VALID and COUNT_RST never assert in the same cycle.

Decomposition:
- Package popcount_pkg holds:
  - register offset localparams: ADDR_DATA, ADDR_COUNT, ADDR_CTRL, ADDR_WCNT;
  - AXI response constants: RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - enum types wr_state_t and rd_state_t.
- No sub-module; the two FSMs share one module. The strobe-masking function lives in the package.

Test Plan:
1. Reset, then AW+W same cycle: DATA=0xFFFFFFFF, WSTRB=0xF, BUSY=0 -> WRITE_VALID one cycle with WRITE_DATA=0xFFFFFFFF; BRESP=OKAY; read WCNT=1.
2. W arrives 3 cycles before AW: DATA=0x0F0F0F0F, WSTRB=0x3 -> WRITE_DATA=0x00000F0F; single pulse only after AW handshake.
3. BUSY high for 10 cycles during a DATA write -> WRITE_VALID exactly one cycle after BUSY falls. With STALL_LIMIT=8 and BUSY stuck high -> no pulse, BRESP=SLVERR, WCNT unchanged.
4. Drive COUNT=37, read 0x4 with RREADY low for 4 cycles -> RVALID held, RDATA=37 stable. Read 0x8 with BUSY=1 -> RDATA=1.
5. Write CTRL=0x1 -> COUNT_RST one cycle; WCNT reads 0. Write CTRL=0x1 with WSTRB=0x2 -> no COUNT_RST.
6. Deassert ARESETN during W_EXEC stall and during R_DATA -> all outputs 0 immediately; after release, no stray WRITE_VALID, BVALID or RVALID.
